// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: data width,
// ALU opcodes and FSM state encoding.
package ex_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;

  localparam logic [1:0] EX_IDLE = 2'd0;
  localparam logic [1:0] EX_BUSY = 2'd1;
  localparam logic [1:0] EX_DONE = 2'd2;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle. master = ID/EX side (drives
// the *_in signals), slave = ex_stage (drives *_out, stall).
interface ex_stage_if;
  import ex_pkg::*;

  logic            valid_in;
  logic [XLEN-1:0] data_1_in;
  logic [XLEN-1:0] data_2_in;
  logic [4:0]      Rd_in;
  logic [3:0]      ALU_ctrl_in;
  logic            ALU_src_in;
  logic [XLEN-1:0] imm_in;

  logic [XLEN-1:0] alu_result_out;
  logic [XLEN-1:0] data_2_out;
  logic [4:0]      Rd_out;
  logic            valid_out;
  logic            stall_out;

  modport master (
    output valid_in, data_1_in, data_2_in,
    output Rd_in, ALU_ctrl_in, ALU_src_in,
    output imm_in,
    input  alu_result_out, data_2_out,
    input  Rd_out, valid_out, stall_out
  );

  modport slave (
    input  valid_in, data_1_in, data_2_in,
    input  Rd_in, ALU_ctrl_in, ALU_src_in,
    input  imm_in,
    output alu_result_out, data_2_out,
    output Rd_out, valid_out, stall_out
  );

endinterface

// File: rtl/ex_stage_mul_iter.sv
// Iterative shift-add multiplier, low 32 bits of a*b.
// Ports: clk, reset, start, a, b -> product_lo, done.
module mul_iter
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] product_lo,
  output logic            done
);

  logic            r_busy;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_acc;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic            w_last;

  // high while the final iteration is being performed
  assign w_last =
    r_busy && (r_cnt == 5'(MUL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_a    <= a;
      r_b    <= b;
    end else if (r_busy) begin
      if (r_b[0])
        r_acc <= r_acc + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 5'd1;
      if (w_last)
        r_busy <= 1'b0;
    end
  end

  assign product_lo = r_acc;
  assign done       = w_last;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand-B mux, ALU, multi-cycle MUL FSM,
// EX/MEM output register. Ports: clk, reset, bus (slave).
module ex_stage
  import ex_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic     clk,
  input  logic     reset,
  ex_stage_if.slave bus
);

  logic [1:0]      r_state;
  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_data_2;
  logic [4:0]      r_rd;
  logic            r_valid;

  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu;
  logic            w_is_mul;
  logic            w_idle;
  logic            w_start;
  logic [XLEN-1:0] w_prod;
  logic            w_mul_done;

  assign w_a     = bus.data_1_in;
  assign w_b     = bus.ALU_src_in ? bus.imm_in
                                  : bus.data_2_in;
  assign w_shamt = w_b[4:0];

  assign w_is_mul =
    bus.valid_in && (bus.ALU_ctrl_in == ALU_MUL);
  assign w_idle  = (r_state == EX_IDLE);
  assign w_start = w_idle && w_is_mul;

  always_comb begin
    w_alu = '0;
    unique case (bus.ALU_ctrl_in)
      ALU_ADD:  w_alu = w_a + w_b;
      ALU_SUB:  w_alu = w_a - w_b;
      ALU_AND:  w_alu = w_a & w_b;
      ALU_OR:   w_alu = w_a | w_b;
      ALU_XOR:  w_alu = w_a ^ w_b;
      ALU_SLL:  w_alu = w_a << w_shamt;
      ALU_SRL:  w_alu = w_a >> w_shamt;
      ALU_SRA:
        w_alu = $unsigned($signed(w_a) >>> w_shamt);
      ALU_SLT:
        w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      ALU_SLTU:
        w_alu = {31'd0, w_a < w_b};
      // MUL goes through mul_iter; reserved ops give 0
      default:  w_alu = '0;
    endcase
  end

  mul_iter #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk        (clk),
    .reset      (reset),
    .start      (w_start),
    .a          (w_a),
    .b          (w_b),
    .product_lo (w_prod),
    .done       (w_mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EX_IDLE;
    end else begin
      unique case (r_state)
        EX_IDLE:
          if (w_is_mul) r_state <= EX_BUSY;
        EX_BUSY:
          if (w_mul_done) r_state <= EX_DONE;
        EX_DONE:
          r_state <= EX_IDLE;
        default:
          r_state <= EX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_data_2 <= '0;
      r_rd     <= '0;
      r_valid  <= 1'b0;
    end else if (r_state == EX_DONE) begin
      // upstream held the MUL, so Rd/rs2 are still valid
      r_result <= w_prod;
      r_data_2 <= bus.data_2_in;
      r_rd     <= bus.Rd_in;
      r_valid  <= 1'b1;
    end else if (w_idle && !w_is_mul) begin
      r_result <= w_alu;
      r_data_2 <= bus.data_2_in;
      r_rd     <= bus.Rd_in;
      r_valid  <= bus.valid_in;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign bus.stall_out =
    w_start || (r_state == EX_BUSY);

  assign bus.alu_result_out = r_result;
  assign bus.data_2_out     = r_data_2;
  assign bus.Rd_out         = r_rd;
  assign bus.valid_out      = r_valid;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage.
// Hand-computed vectors, immediate assertions.
module tb_ex_stage;
  import ex_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_stall;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b2,
    input logic        src,
    input logic [31:0] imm,
    input logic [4:0]  rd
  );
    bus.valid_in    = v;
    bus.ALU_ctrl_in = op;
    bus.data_1_in   = a;
    bus.data_2_in   = b2;
    bus.ALU_src_in  = src;
    bus.imm_in      = imm;
    bus.Rd_in       = rd;
  endtask

  task automatic run1(
    input string       tag,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b2,
    input logic [4:0]  rd,
    input logic [31:0] exp
  );
    drive(1'b1, op, a, b2, 1'b0, 32'd0, rd);
    #1;
    chk({tag, "_stall"}, {31'd0, bus.stall_out}, 0);
    tick;
    chk({tag, "_res"}, bus.alu_result_out, exp);
    chk({tag, "_rd"}, {27'd0, bus.Rd_out},
        {27'd0, rd});
    chk({tag, "_vld"}, {31'd0, bus.valid_out}, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_res"}, bus.alu_result_out, 0);
    chk({tag, "_d2"}, bus.data_2_out, 0);
    chk({tag, "_rd"}, {27'd0, bus.Rd_out}, 0);
    chk({tag, "_vld"}, {31'd0, bus.valid_out}, 0);
    chk({tag, "_stall"}, {31'd0, bus.stall_out}, 0);
    chk({tag, "_state"}, {30'd0, dut.r_state},
        {30'd0, EX_IDLE});
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b1, 4'($urandom), $urandom, $urandom,
          1'($urandom), $urandom, 5'($urandom));
    tick;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    drive(1'b0, ALU_ADD, 0, 0, 1'b0, 0, 0);
    #1;
    chk_zero("reset");

    run1("add",  ALU_ADD,  32'd7, 32'd5, 5'd5, 32'd12);
    run1("sub",  ALU_SUB,  32'd5, 32'd7, 5'd6,
         32'hFFFF_FFFE);
    run1("sra",  ALU_SRA,  32'h8000_0000, 32'h21, 5'd7,
         32'hC000_0000);
    run1("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd8,
         32'd1);
    run1("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd9,
         32'd0);

    // immediate selected as operand B, rs2 passed through
    drive(1'b1, ALU_ADD, 32'd1, 32'd100, 1'b1,
          32'hFFFF_FFFF, 5'd10);
    tick;
    chk("src_res", bus.alu_result_out, 32'd0);
    chk("src_d2", bus.data_2_out, 32'd100);
    chk("src_rd", {27'd0, bus.Rd_out}, 32'd10);

    // multiply: cycle 0 = presentation cycle
    drive(1'b1, ALU_MUL, 32'h1234_5678,
          32'h9ABC_DEF0, 1'b0, 0, 5'd3);
    #1;
    n_stall = bus.stall_out ? 1 : 0;
    for (int c = 1; c <= 33; c++) begin
      tick;
      chk("mul_vld_low", {31'd0, bus.valid_out}, 0);
      if (bus.stall_out) n_stall++;
      if (c == 33)
        chk("mul_done_stall",
            {31'd0, bus.stall_out}, 0);
    end
    chk("mul_stall_cnt", n_stall, 33);
    tick;
    chk("mul_res", bus.alu_result_out, 32'h242D_2080);
    chk("mul_rd", {27'd0, bus.Rd_out}, 32'd3);
    chk("mul_vld", {31'd0, bus.valid_out}, 1);
    chk("mul_d2", bus.data_2_out, 32'h9ABC_DEF0);
    // ADD queued behind the MUL, presented in cycle 34
    drive(1'b1, ALU_ADD, 32'd2, 32'd3, 1'b0, 0, 5'd4);
    #1;
    chk("q_stall", {31'd0, bus.stall_out}, 0);
    tick;
    chk("q_res", bus.alu_result_out, 32'd5);
    chk("q_rd", {27'd0, bus.Rd_out}, 32'd4);
    chk("q_vld", {31'd0, bus.valid_out}, 1);

    // reset in cycle 10 of a multiply
    drive(1'b1, ALU_MUL, 32'd3, 32'd4, 1'b0, 0, 5'd12);
    for (int c = 1; c <= 10; c++) tick;
    chk("mid_busy", {30'd0, dut.r_state},
        {30'd0, EX_BUSY});
    reset = 1'b1;
    drive(1'b0, ALU_ADD, 0, 0, 1'b0, 0, 0);
    tick;
    reset = 1'b0;
    chk_zero("mid_rst");
    run1("post", ALU_ADD, 32'd10, 32'd20, 5'd1,
         32'd30);

    run1("rsvd", 4'd13, 32'd5, 32'd6, 5'd14, 32'd0);

    // bubble carrying a MUL opcode must not start it
    drive(1'b0, ALU_MUL, 32'd5, 32'd6, 1'b0, 0, 5'd2);
    #1;
    chk("bub_stall", {31'd0, bus.stall_out}, 0);
    tick;
    chk("bub_vld", {31'd0, bus.valid_out}, 0);
    chk("bub_rd", {27'd0, bus.Rd_out}, 32'd2);
    chk("bub_d2", bus.data_2_out, 32'd6);
    chk("bub_state", {30'd0, dut.r_state},
        {30'd0, EX_IDLE});
    chk("bub_stall2", {31'd0, bus.stall_out}, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-V pipeline: the consumer of the ID/EX pipeline register outputs. Selects operand B, runs the ALU (single-cycle ops plus an iterative 32-cycle multiply), and registers results into the EX/MEM boundary. During a multiply it raises a stall so the upstream stages hold the ID/EX contents.

## Interface
Parameters:
- `MUL_CYCLES`, default 32: multiply iterations. Fixed at 32 for this release; not otherwise configurable.

Ports:
- `clk`  in  1: single clock; all state changes on posedge.
- `reset`  in  1: synchronous, active-high.
- `valid_in`  in  1: ID/EX holds a real instruction (0 = bubble).
- `data_1_in`  in  32: rs1 value (operand A).
- `data_2_in`  in  32: rs2 value (operand B or store data).
- `Rd_in`  in  5: destination register.
- `ALU_ctrl_in`  in  4: ALU operation code.
- `ALU_src_in`  in  1: 1 selects `imm_in` as operand B, 0 selects `data_2_in`.
- `imm_in`  in  32: sign-extended immediate.
- `alu_result_out`  out  32: registered ALU result.
- `data_2_out`  out  32: registered rs2 value (store data).
- `Rd_out`  out  5: registered destination.
- `valid_out`  out  1: registered; EX/MEM entry is real.
- `stall_out`  out  1: combinational; upstream (PC, IF/ID, ID/EX) holds while high.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA: shift amount is B[4:0].
  - 8 SLT (signed), 9 SLTU.
  - 10 MUL: low 32 bits of A*B.
  - 11–15 reserved: result 0, treated as single-cycle.
- Arithmetic wraps modulo 2^32. SLT and SLTU produce 32'd0 or 32'd1.
- States:
  - IDLE to BUSY when `valid_in`=1 and op=MUL. Latch A and B, set counter to 0.
  - BUSY: one shift-add iteration per cycle, counter increments. Go to DONE when counter==31, after the iteration is performed.
  - DONE to IDLE unconditionally. On this edge, load the product into the outputs.
- `stall_out` = (IDLE & `valid_in` & op==MUL) | BUSY. It is low in DONE.
- Output register, every edge:
  - IDLE, non-MUL: capture result, `data_2_in`, `Rd_in`, `valid_in`.
  - IDLE, MUL or BUSY: `valid_out`=0. `alu_result_out`, `Rd_out` and `data_2_out` hold their values.
  - DONE: capture product, `Rd_in`, `data_2_in`, `valid_out`=1. The MUL is still presented because upstream held it.
- A bubble (`valid_in`=0) in IDLE: `valid_out`=0. The other outputs still capture.
- Reset, including mid-multiply: state goes to IDLE, counter to 0, and all outputs go to 0 (`alu_result_out`, `data_2_out`, `Rd_out`, `valid_out`). `stall_out` is 0 in the cycle after reset unless a MUL is presented.

## Timing
- Single-cycle ops: presented in cycle N, visible on outputs in cycle N+1.
- MUL:
  - Presented in cycle 0. BUSY in cycles 1–32. DONE in cycle 33.
  - Result visible in cycle 34, a latency of 34.
  - `stall_out` is high in cycles 0–32 (33 cycles).
- In the DONE cycle, `stall_out`=0, so ID/EX loads the next instruction on the same edge that the product is output.
- Back-to-back MULs: the second MUL is presented in cycle 34 and starts a new 34-cycle sequence. There is no idle gap.

## Structure
- Shared package `ex_pkg` holds:
  - ALU opcode localparams (`ALU_ADD` … `ALU_MUL`).
  - State encoding (`EX_IDLE`, `EX_BUSY`, `EX_DONE`).
  - Data width 32.
- Sub-module `mul_iter`: iterative shift-add multiplier.
  - Inputs: start, a, b. Outputs: product_lo, done.
  - Holds the 32-bit accumulator and the 5-bit counter.
  - `ex_stage` keeps the FSM, the operand-B mux, the combinational ALU and the output register.

## Test plan
- Reset: hold `reset` for 2 cycles after random inputs. Require all outputs 0, `stall_out`=0 and state IDLE.
- Single-cycle ops:
  - ADD 7+5 → 12.
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000 by B=0x21 → 0xC0000000 (shift amount 1).
  - SLT -1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - Each result appears 1 cycle later with `Rd_out` and `valid_out` matching the input.
- ALU_src: `ALU_src_in`=1, `imm_in`=0xFFFFFFFF, `data_2_in`=100, ADD with A=1 → 0, and `data_2_out`=100.
- MUL: 0x12345678 × 0x9ABCDEF0, `Rd_in`=3. Require:
  - `stall_out` high for exactly 33 cycles.
  - `valid_out`=0 for cycles 1–33.
  - Cycle 34: result 0x242D2080, `Rd_out`=3, `valid_out`=1.
  - An ADD queued behind the MUL appears in cycle 35.
- Reset mid-MUL: assert `reset` in cycle 10 of a MUL. Require outputs 0 and `stall_out`=0 next cycle, then a fresh ADD completes normally.
- Bubble and reserved ops:
  - `valid_in`=0 with op=MUL: no stall, `valid_out`=0.
  - Op 13 with `valid_in`=1: result 0, `valid_out`=1.
